// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment scan driver.
// Holds the active-high glyph patterns (bit0=a .. bit6=g), the dash nibble
// code and the segment vector type used by the glyph decoder and the top.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_ZERO  = 7'b0111111;
  localparam seg_t SEG_ONE   = 7'b0000110;
  localparam seg_t SEG_TWO   = 7'b1011011;
  localparam seg_t SEG_THREE = 7'b1001111;
  localparam seg_t SEG_FOUR  = 7'b1100110;
  localparam seg_t SEG_FIVE  = 7'b1101101;
  localparam seg_t SEG_SIX   = 7'b1111101;
  localparam seg_t SEG_SEVEN = 7'b0000111;
  localparam seg_t SEG_EIGHT = 7'b1111111;
  localparam seg_t SEG_NINE  = 7'b1101111;
  localparam seg_t SEG_DASH  = 7'b1000000;
  localparam seg_t SEG_OFF   = 7'b0000000;

  localparam logic [3:0] CODE_DASH = 4'hA;

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational nibble-to-glyph lookup, active-high segments.
// Ports: nib (4-bit code in), seg (seg_t pattern out).
// Codes 0-9 are digits, CODE_DASH is a dash, everything above is blank.
module seg_glyph
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0:      seg = SEG_ZERO;
      4'h1:      seg = SEG_ONE;
      4'h2:      seg = SEG_TWO;
      4'h3:      seg = SEG_THREE;
      4'h4:      seg = SEG_FOUR;
      4'h5:      seg = SEG_FIVE;
      4'h6:      seg = SEG_SIX;
      4'h7:      seg = SEG_SEVEN;
      4'h8:      seg = SEG_EIGHT;
      4'h9:      seg = SEG_NINE;
      CODE_DASH: seg = SEG_DASH;
      default:   seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with a shadow register
// and an all-anodes-off guard interval at the start of every digit slot.
// Ports: clk_in/rst_in (sync, active-high); val_in/dp_in/blank_in captured on
// valid_in; cat_out/dp_out/an_out are registered, active-low pin drives.
// Optional build macro SEVEN_SEG_LZB_EN enables leading-zero blanking.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int COUNT_PERIOD = 100000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] val_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    valid_in,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int CNT_W = $clog2(COUNT_PERIOD);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_PERIOD - 1);
  localparam logic [CNT_W-1:0] GUARD    = CNT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Suppress mask consistent with an all-zero shadow: with blanking enabled
  // every digit but the least significant one is dark after reset.
`ifdef SEVEN_SEG_LZB_EN
  localparam logic [NUM_DIGITS-1:0] SUP_RESET = ~NUM_DIGITS'(1);
`else
  localparam logic [NUM_DIGITS-1:0] SUP_RESET = '0;
`endif

  logic [CNT_W-1:0]           cnt;
  logic [IDX_W-1:0]           idx;
  logic [NUM_DIGITS-1:0][3:0] val_q;
  logic [NUM_DIGITS-1:0]      dp_q;
  logic [NUM_DIGITS-1:0]      blank_q;
  logic [NUM_DIGITS-1:0]      sup_q;
  logic [NUM_DIGITS-1:0]      sup_d;

  logic [3:0]                 cur_nib;
  logic                       cur_dp;
  logic                       cur_dark;
  seg_t                       glyph;

  logic [NUM_DIGITS-1:0]      an_d;
  logic [6:0]                 cat_d;
  logic                       dp_d;

  // Slot counter and digit index.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Suppress mask is derived from the incoming word so it lands in the same
  // cycle as the shadow data it belongs to.
`ifdef SEVEN_SEG_LZB_EN
  logic lz_run;
  always_comb begin
    sup_d  = '0;
    lz_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lz_run   = lz_run & (val_in[4*k +: 4] == 4'h0);
      sup_d[k] = lz_run;
    end
  end
`else
  assign sup_d = '0;
`endif

  // Shadow register: all fields load together.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      val_q   <= '0;
      dp_q    <= '0;
      blank_q <= '0;
      sup_q   <= SUP_RESET;
    end else if (valid_in) begin
      val_q   <= val_in;
      dp_q    <= dp_in;
      blank_q <= blank_in;
      sup_q   <= sup_d;
    end
  end

  assign cur_nib  = val_q[idx];
  assign cur_dp   = dp_q[idx];
  assign cur_dark = blank_q[idx] | sup_q[idx];

  seg_glyph u_glyph (
    .nib (cur_nib),
    .seg (glyph)
  );

  // Pin values for the next cycle; dark during the guard window. A blanked
  // digit still gets its anode so the scan timing stays uniform.
  always_comb begin
    an_d  = '1;
    cat_d = 7'h7F;
    dp_d  = 1'b1;
    if (!(cnt < GUARD)) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = (idx != IDX_W'(k));
      end
      if (!cur_dark) begin
        cat_d = ~glyph;
        dp_d  = ~cur_dp;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      an_out  <= '1;
      cat_out <= 7'h7F;
      dp_out  <= 1'b1;
    end else begin
      an_out  <= an_d;
      cat_out <= cat_d;
      dp_out  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan (4 digits, 8-cycle slots, 2 guard cycles).
// Stimulus pushes the expected pin state for the next edge; a monitor pops and
// compares one entry every cycle.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int CP = 8;
  localparam int GC = 2;

  typedef struct packed {
    logic [ND-1:0] an;
    logic [6:0]    cat;
    logic          dp;
  } pins_t;

  localparam pins_t DARK = '{an: '1, cat: 7'h7F, dp: 1'b1};

  logic            clk = 1'b0;
  logic            rst;
  logic [4*ND-1:0] val;
  logic [ND-1:0]   dp;
  logic [ND-1:0]   blank;
  logic            valid;
  logic [6:0]      cat_out;
  logic            dp_out;
  logic [ND-1:0]   an_out;

  always #5 clk = ~clk;

  seven_seg_scan #(
    .NUM_DIGITS   (ND),
    .COUNT_PERIOD (CP),
    .GUARD_CYCLES (GC)
  ) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .val_in   (val),
    .dp_in    (dp),
    .blank_in (blank),
    .valid_in (valid),
    .cat_out  (cat_out),
    .dp_out   (dp_out),
    .an_out   (an_out)
  );

  pins_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  // Reference state: cycles elapsed since reset and the last captured data.
  int              e;
  logic [4*ND-1:0] m_val;
  logic [ND-1:0]   m_dp;
  logic [ND-1:0]   m_blank;
  logic [6:0]      glyph_tab [16];

  function automatic pins_t model_pins();
    pins_t p;
    int    pos;
    int    dig;
    logic  dark;
    p   = DARK;
    pos = e % CP;
    dig = (e / CP) % ND;
    if (pos >= GC) begin
      p.an[dig] = 1'b0;
      dark      = m_blank[dig];
`ifdef SEVEN_SEG_LZB_EN
      if (dig > 0 && (m_val >> (4 * dig)) == 0) dark = 1'b1;
`endif
      if (!dark) begin
        p.cat = ~glyph_tab[m_val[4*dig +: 4]];
        p.dp  = ~m_dp[dig];
      end
    end
    return p;
  endfunction

  task automatic step(input logic r, input logic v, input logic [4*ND-1:0] nv,
                      input logic [ND-1:0] nd, input logic [ND-1:0] nb);
    @(negedge clk);
    rst   = r;
    valid = v;
    val   = nv;
    dp    = nd;
    blank = nb;
    exp_q.push_back(r ? DARK : model_pins());
    if (r) begin
      e       = 0;
      m_val   = '0;
      m_dp    = '0;
      m_blank = '0;
    end else begin
      e++;
      if (v) begin
        m_val   = nv;
        m_dp    = nd;
        m_blank = nb;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic load(input logic [4*ND-1:0] nv, input logic [ND-1:0] nd,
                      input logic [ND-1:0] nb);
    step(1'b0, 1'b1, nv, nd, nb);
  endtask

  // Monitor: one comparison per cycle, sampled just after the active edge.
  initial begin
    pins_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        vectors++;
        if ({an_out, cat_out, dp_out} !== x) begin
          miscompares++;
          $display("FAIL pins @%0t: got an=%b cat=%h dp=%b, expected an=%b cat=%h dp=%b",
                   $time, an_out, cat_out, dp_out, x.an, x.cat, x.dp);
        end
      end
    end
  end

  initial begin
    glyph_tab[0]  = 7'b0111111; glyph_tab[1]  = 7'b0000110;
    glyph_tab[2]  = 7'b1011011; glyph_tab[3]  = 7'b1001111;
    glyph_tab[4]  = 7'b1100110; glyph_tab[5]  = 7'b1101101;
    glyph_tab[6]  = 7'b1111101; glyph_tab[7]  = 7'b0000111;
    glyph_tab[8]  = 7'b1111111; glyph_tab[9]  = 7'b1101111;
    glyph_tab[10] = 7'b1000000;
    for (int i = 11; i < 16; i++) glyph_tab[i] = 7'b0000000;

    rst = 1'b1; valid = 1'b0; val = '0; dp = '0; blank = '0;
    e = 0; m_val = '0; m_dp = '0; m_blank = '0;

    // Reset and the all-zero display.
    step(1'b1, 1'b0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0);
    idle(40);

    // Mixed glyphs with one decimal point.
    load(16'hA987, 4'b0010, 4'b0000);
    idle(40);

    // Forced blank on digit 2.
    load(16'h8888, 4'b0000, 4'b0100);
    idle(40);

    // Data change inside the digit 0 active window.
    step(1'b1, 1'b0, '0, '0, '0);
    load(16'h0001, 4'b0000, 4'b0000);
    idle(3);
    load(16'h0002, 4'b0000, 4'b0000);
    idle(12);

    // Reset in the middle of the digit 2 slot.
    while (((e / CP) % ND) != 2) idle(1);
    idle(3);
    step(1'b1, 1'b0, '0, '0, '0);
    idle(20);

    // Leading-zero patterns.
    load(16'h0050, 4'b0000, 4'b0000);
    idle(34);
    load(16'h0000, 4'b0000, 4'b0000);
    idle(34);

    // Load landing exactly on a slot wrap.
    while ((e % CP) != CP - 1) idle(1);
    load(16'h4321, 4'b1001, 4'b0000);
    idle(12);

    // valid held high: last value wins.
    for (int i = 0; i < 6; i++) load(16'($urandom), 4'($urandom), 4'($urandom));
    idle(34);

    // Randomized traffic with sparse loads and rare resets.
    for (int i = 0; i < 900; i++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 5) == 0,
           16'($urandom) & 16'($urandom), 4'($urandom), 4'($urandom) & 4'($urandom));
    end

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
